// File: rtl/jtcontra_gfx_romslot_if.sv
// jtcontra_gfx_romslot_if
// Groups the gfx-side ROM request port and the SDRAM-side read port used by
// jtcontra_gfx_romslot.
//
// Signals:
//   slot_cs, slot_addr[17:0]  gfx request: word address valid while slot_cs=1
//   slot_ok, slot_dout[15:0]  slot_dout holds the word for slot_addr when slot_ok=1
//   sdram_req, sdram_addr     read request, held high until sdram_ack
//   sdram_ack                 one-cycle pulse: controller accepted the request
//   sdram_dst, sdram_din      one-cycle pulse: sdram_din carries the read word
//
// Handshake: sdram_req rises with a stable sdram_addr and stays high until the
// edge that samples sdram_ack=1. The data return is a separate sdram_dst pulse,
// which may coincide with the ack cycle or come later. slot_cs/slot_addr have
// no back-pressure; the requester simply holds them until slot_ok is seen.
//
// Modports: slave = the ROM slot responder, master = gfx requester plus SDRAM
// controller side.
interface jtcontra_gfx_romslot_if #(
    parameter int AW = 22
);
    logic          slot_cs;
    logic [17:0]   slot_addr;
    logic          slot_ok;
    logic [15:0]   slot_dout;
    logic          sdram_req;
    logic [AW-1:0] sdram_addr;
    logic          sdram_ack;
    logic          sdram_dst;
    logic [15:0]   sdram_din;

    modport slave (
        input  slot_cs, slot_addr,
        output slot_ok, slot_dout,
        output sdram_req, sdram_addr,
        input  sdram_ack, sdram_dst, sdram_din
    );

    modport master (
        output slot_cs, slot_addr,
        input  slot_ok, slot_dout,
        input  sdram_req, sdram_addr,
        output sdram_ack, sdram_dst, sdram_din
    );
endinterface

// File: rtl/jtcontra_gfx_romslot.sv
// jtcontra_gfx_romslot
// SDRAM-side responder for one gfx ROM request port. A one-word tag/data
// cache answers repeated fetches of the same word combinationally; a miss
// issues a single-word SDRAM read and re-issues it if the data never returns.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   downloading  ROM download in progress: flushes the cache, blocks requests
//   bus          slot + SDRAM signals (jtcontra_gfx_romslot_if.slave)
//   dbg_state_o  current FSM state (0=IDLE, 1=REQ, 2=WAIT)
module jtcontra_gfx_romslot #(
    parameter int          AW     = 22,
    parameter logic [AW-1:0] OFFSET = '0,
    parameter int unsigned TOUT   = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         downloading,
    jtcontra_gfx_romslot_if.slave        bus,
    output logic [1:0]                   dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    // WAIT lasts TOUT cycles before the request is re-issued.
    localparam logic [7:0] TOUT_LAST = 8'(TOUT - 1);

    state_t        state_q, state_d;
    logic [17:0]   tag_q, tag_d;
    logic [17:0]   req_addr_q, req_addr_d;
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          req_q, req_d;
    logic [7:0]    tout_q, tout_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          hit;

    assign hit = valid_q && (bus.slot_addr == tag_q);

    assign bus.slot_ok    = bus.slot_cs && hit && !downloading;
    assign bus.slot_dout  = data_q;
    assign bus.sdram_req  = req_q;
    assign bus.sdram_addr = addr_q;
    assign dbg_state_o    = state_q;

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        req_addr_d = req_addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        req_d      = req_q;
        tout_d     = tout_q;
        addr_d     = addr_q;
        if (downloading) begin
            state_d = IDLE;
            req_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.slot_cs && !hit) begin
                        req_addr_d = bus.slot_addr;
                        addr_d     = OFFSET + AW'(bus.slot_addr);
                        req_d      = 1'b1;
                        // Stale data must not match while the new word is in flight.
                        valid_d    = 1'b0;
                        state_d    = REQ;
                    end
                end
                REQ: begin
                    if (bus.sdram_ack) begin
                        req_d  = 1'b0;
                        tout_d = '0;
                        if (bus.sdram_dst) begin
                            // Data returned together with the ack.
                            data_d  = bus.sdram_din;
                            tag_d   = req_addr_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.sdram_dst) begin
                        data_d  = bus.sdram_din;
                        tag_d   = req_addr_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else if (tout_q == TOUT_LAST) begin
                        // Data lost: re-issue the same address.
                        req_d   = 1'b1;
                        state_d = REQ;
                    end else begin
                        tout_d = tout_q + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            req_addr_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            tout_q     <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            req_addr_q <= req_addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
            tout_q     <= tout_d;
            addr_q     <= addr_d;
        end
    end
endmodule

// File: tb/tb_jtcontra_gfx_romslot.sv
module tb_jtcontra_gfx_romslot;
    localparam int            AW     = 22;
    localparam logic [AW-1:0] OFFSET = 22'h080000;
    localparam int            TOUT   = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic downloading = 1'b0;
    logic [1:0] dbg_state;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jtcontra_gfx_romslot_if #(.AW(AW)) bus ();

    jtcontra_gfx_romslot #(.AW(AW), .OFFSET(OFFSET), .TOUT(TOUT)) dut (
        .clk(clk),
        .rst(rst),
        .downloading(downloading),
        .bus(bus),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [15:0]   exp_dout_q[$];

    // Reference model: ROM contents plus the single cached word.
    logic [15:0] rom [0:255];
    logic        m_valid = 1'b0;
    logic [17:0] m_tag = '0;

    bit resp_on = 0;
    bit mon_on = 0;
    int withhold = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string msg);
        checks++;
        errors++;
        $display("FAIL %s", msg);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    // Presents one address until slot_ok, predicting from the model whether it
    // is a hit and what SDRAM traffic it causes. first_ok is slot_ok in the
    // very cycle the address is first presented.
    task automatic fetch(input logic [17:0] a, input int wh, output logic first_ok);
        int n;
        logic h;
        h = m_valid && (m_tag == a);
        exp_dout_q.push_back(rom[a[7:0]]);
        if (!h) begin
            repeat (1 + wh) exp_addr_q.push_back(OFFSET + AW'(a));
            withhold = wh;
            m_valid = 1'b1;
            m_tag = a;
        end
        step;
        bus.slot_cs = 1'b1;
        bus.slot_addr = a;
        @(negedge clk);
        first_ok = bus.slot_ok;
        n = 0;
        while (!bus.slot_ok && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.slot_ok) fail($sformatf("fetch_timeout addr=%h: slot_ok=0 required 1", a));
        step;
        bus.slot_cs = 1'b0;
    endtask

    // ---------------- SDRAM responder ----------------
    int ack_cyc;
    always begin : responder
        int ad, dd, w;
        logic [AW-1:0] off;
        step;
        if (resp_on && bus.sdram_req) begin
            ad = $urandom_range(0, 3);
            dd = $urandom_range(0, 3);
            repeat (ad) step;
            off = bus.sdram_addr - OFFSET;
            bus.sdram_ack = 1'b1;
            if (withhold == 0 && dd == 0) begin
                bus.sdram_dst = 1'b1;
                bus.sdram_din = rom[off[7:0]];
            end
            step;
            bus.sdram_ack = 1'b0;
            bus.sdram_dst = 1'b0;
            if (withhold > 0) begin
                withhold--;
                ack_cyc = cyc;
                w = 0;
                while (!bus.sdram_req && w < TOUT + 4) begin
                    step;
                    w++;
                end
                check("retry_delay", cyc - ack_cyc, TOUT);
            end else if (dd > 0) begin
                repeat (dd - 1) step;
                bus.sdram_dst = 1'b1;
                bus.sdram_din = rom[off[7:0]];
                step;
                bus.sdram_dst = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic prev_ok = 1'b0;
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.slot_ok && !prev_ok) begin
                if (exp_dout_q.size() == 0) fail($sformatf("unexpected_ok: slot_ok=1 dout=%h required no response", bus.slot_dout));
                else check("slot_dout", bus.slot_dout, exp_dout_q.pop_front());
            end
            if (bus.sdram_req && !prev_req) begin
                if (exp_addr_q.size() == 0) fail($sformatf("unexpected_req: sdram_req=1 addr=%h required no request", bus.sdram_addr));
                else check("sdram_addr", bus.sdram_addr, exp_addr_q.pop_front());
            end
        end
        prev_ok <= bus.slot_ok;
        prev_req <= bus.sdram_req;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic fo, h;
        logic [17:0] ra;
        int wh;
        bus.slot_cs = 1'b1;
        bus.slot_addr = '0;
        bus.sdram_ack = 1'b0;
        bus.sdram_dst = 1'b0;
        bus.sdram_din = '0;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[8'h10] = 16'hA5C3;
        rom[8'h3F] = 16'h1234;

        // Reset values (cs high with addr equal to the reset tag).
        repeat (3) step;
        @(negedge clk);
        check("rst_req", bus.sdram_req, 0);
        check("rst_ok", bus.slot_ok, 0);
        check("rst_dout", bus.slot_dout, 0);
        check("rst_addr", bus.sdram_addr, 0);
        check("rst_state", dbg_state, 0);
        step;
        bus.slot_cs = 1'b0;
        rst = 1'b1;
        mon_on = 1;

        // First miss, manual SDRAM handshake.
        step;
        bus.slot_cs = 1'b1;
        bus.slot_addr = 18'h00010;
        exp_addr_q.push_back(22'h080010);
        exp_dout_q.push_back(16'hA5C3);
        @(negedge clk);
        check("miss_req_c0", bus.sdram_req, 0);
        step;
        @(negedge clk);
        check("miss_req_c1", bus.sdram_req, 1);
        check("miss_addr", bus.sdram_addr, 22'h080010);
        step;
        step;
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        check("req_held", bus.sdram_req, 1);
        step;
        bus.sdram_ack = 1'b0;
        @(negedge clk);
        check("req_drop", bus.sdram_req, 0);
        step;
        bus.sdram_dst = 1'b1;
        bus.sdram_din = 16'hA5C3;
        @(negedge clk);
        check("ok_in_dst_cycle", bus.slot_ok, 0);
        step;
        bus.sdram_dst = 1'b0;
        bus.sdram_din = 16'h0000;
        @(negedge clk);
        check("ok_after_dst", bus.slot_ok, 1);
        check("dout_after_dst", bus.slot_dout, 16'hA5C3);
        m_valid = 1'b1;
        m_tag = 18'h00010;

        // Held address: stays a hit, no SDRAM traffic.
        for (int i = 0; i < 10; i++) begin
            step;
            @(negedge clk);
            check("hold_ok", bus.slot_ok, 1);
            check("hold_req", bus.sdram_req, 0);
        end

        // Download pulse flushes the cache; same address misses again.
        step;
        downloading = 1'b1;
        @(negedge clk);
        check("dl_ok", bus.slot_ok, 0);
        step;
        downloading = 1'b0;
        m_valid = 1'b0;
        exp_addr_q.push_back(22'h080010);
        @(negedge clk);
        check("dl_ok_after", bus.slot_ok, 0);
        check("dl_req_c0", bus.sdram_req, 0);
        step;
        @(negedge clk);
        check("dl_req_c1", bus.sdram_req, 1);

        // Address changes while in WAIT: read completes, then a fresh miss.
        step;
        bus.sdram_ack = 1'b1;
        step;
        bus.sdram_ack = 1'b0;
        bus.slot_addr = 18'h00011;
        exp_addr_q.push_back(22'h080011);
        step;
        bus.sdram_dst = 1'b1;
        bus.sdram_din = rom[8'h10];
        @(negedge clk);
        check("chg_req_dst", bus.sdram_req, 0);
        step;
        bus.sdram_dst = 1'b0;
        @(negedge clk);
        check("chg_ok", bus.slot_ok, 0);
        check("chg_req_c0", bus.sdram_req, 0);
        step;
        @(negedge clk);
        check("chg_req_c1", bus.sdram_req, 1);
        check("chg_addr", bus.sdram_addr, 22'h080011);
        // Ack and data together.
        exp_dout_q.push_back(rom[8'h11]);
        step;
        bus.sdram_ack = 1'b1;
        bus.sdram_dst = 1'b1;
        bus.sdram_din = rom[8'h11];
        step;
        bus.sdram_ack = 1'b0;
        bus.sdram_dst = 1'b0;
        @(negedge clk);
        check("ackdst_ok", bus.slot_ok, 1);
        check("ackdst_dout", bus.slot_dout, rom[8'h11]);
        m_valid = 1'b1;
        m_tag = 18'h00011;

        // Reset during WAIT, then a stray dst must be ignored.
        step;
        bus.slot_addr = 18'h00030;
        exp_addr_q.push_back(22'h080030);
        step;
        bus.sdram_ack = 1'b1;
        step;
        bus.sdram_ack = 1'b0;
        step;
        rst = 1'b0;
        bus.slot_cs = 1'b0;
        step;
        rst = 1'b1;
        bus.sdram_dst = 1'b1;
        bus.sdram_din = rom[8'h30];
        @(negedge clk);
        check("rstw_req", bus.sdram_req, 0);
        step;
        bus.sdram_dst = 1'b0;
        @(negedge clk);
        check("rstw_req2", bus.sdram_req, 0);
        check("rstw_dout", bus.slot_dout, 0);
        m_valid = 1'b0;
        resp_on = 1;
        fetch(18'h00030, 0, fo);
        check("rstw_no_capture", fo, 0);

        // Lost data: retried after TOUT cycles with the same address.
        fetch(18'h0003F, 1, fo);
        check("retry_first_ok", fo, 0);

        // Randomized traffic over a small address set to mix hits and misses.
        for (int i = 0; i < 80; i++) begin
            ra = 18'h00010 + 18'($urandom_range(0, 5));
            h = m_valid && (m_tag == ra);
            wh = (!h && $urandom_range(0, 5) == 0) ? 1 : 0;
            fetch(ra, wh, fo);
            check("hit_same_cycle", fo, h);
            if ($urandom_range(0, 9) == 0) begin
                step;
                downloading = 1'b1;
                step;
                downloading = 1'b0;
                m_valid = 1'b0;
            end
        end

        repeat (20) step;
        check("addr_q_drained", exp_addr_q.size(), 0);
        check("dout_q_drained", exp_dout_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
